phys_reg_free_list: RTL and testbench

//  Circular free list of physical register tags for the rename stage. Dispatch pops tags for
//  new destinations; commit pushes back each retiring instruction's old mapping. Produces the

---
 rtl/phys_reg_free_list.sv | 80 ++++++++
 tb/tb_phys_reg_free_list.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for rename. It holds a speculative head for
// dispatch pops and a committed head, so a flush can restore every speculatively popped tag.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
  parameter int PREG_W        = $clog2(NUM_PHYS_REGS),
  parameter int PTR_W         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              commit_alloc,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg,
  output logic              free_list_empty,
  output logic              free_list_full,
  output logic [PTR_W-1:0]  free_count,
  output logic              overflow_err
);
  localparam int IDX_W = PTR_W - 1;

  logic [PREG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  spec_head, commit_head, tail;
  logic [PTR_W-1:0]  commit_head_next;
  logic              push;

  // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1 and toggle the wrap bit.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
      return {~p[PTR_W-1], {IDX_W{1'b0}}};
    else
      return {p[PTR_W-1], p[IDX_W-1:0] + IDX_W'(1)};
  endfunction

  assign free_list_empty = (tail == spec_head);
  assign free_list_full  = (tail[IDX_W-1:0] == spec_head[IDX_W-1:0]) &&
                           (tail[PTR_W-1] != spec_head[PTR_W-1]);

  always_comb begin
    if (tail[PTR_W-1] == spec_head[PTR_W-1])
      free_count = PTR_W'(tail[IDX_W-1:0]) - PTR_W'(spec_head[IDX_W-1:0]);
    else
      free_count = PTR_W'(DEPTH) - PTR_W'(spec_head[IDX_W-1:0]) + PTR_W'(tail[IDX_W-1:0]);
  end

  // Grant is combinational from the registered state; a same-cycle push is never bypassed.
  assign alloc_valid = alloc_req && !free_list_empty && !flush && !rst;
  assign alloc_preg  = mem[spec_head[IDX_W-1:0]];
  assign push        = free_valid && !free_list_full;

  assign commit_head_next = commit_alloc ? ptr_inc(commit_head) : commit_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PREG_W'(NUM_ARCH_REGS + i);
      spec_head    <= '0;
      commit_head  <= '0;
      tail         <= {1'b1, {IDX_W{1'b0}}};
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        mem[tail[IDX_W-1:0]] <= free_preg;
        tail                 <= ptr_inc(tail);
      end
      if (free_valid && free_list_full)
        overflow_err <= 1'b1;
      commit_head <= commit_head_next;
      // Retirement is non-speculative, so a flush still honours the same-cycle commit.
      if (flush)
        spec_head <= commit_head_next;
      else if (alloc_valid)
        spec_head <= ptr_inc(spec_head);
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: pops, pushes, flush recovery, overflow and index wrap.
module tb_phys_reg_free_list;
  localparam int PREG_W = 6;
  localparam int PTR_W  = 6;

  logic              clk = 1'b0;
  logic              rst, flush, alloc_req, commit_alloc, free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              alloc_valid, free_list_empty, free_list_full, overflow_err;
  logic [PREG_W-1:0] alloc_preg;
  logic [PTR_W-1:0]  free_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .commit_alloc(commit_alloc), .free_valid(free_valid), .free_preg(free_preg),
    .free_list_empty(free_list_empty), .free_list_full(free_list_full),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 0; alloc_req = 0; commit_alloc = 0; free_valid = 0; free_preg = '0;
  endtask

  // Advance one edge; inputs are then changed 1 time unit after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0; #1;
  endtask

  task automatic pop_n(input int n, input int first_tag);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1; #1;
      chk("pop_valid", alloc_valid, 1);
      chk("pop_tag", alloc_preg, first_tag + i);
      tick();
    end
    idle(); #1;
  endtask

  int q[$];
  int held;

  initial begin
    // Reset state
    do_reset();
    chk("rst_count", free_count, 32);
    chk("rst_full", free_list_full, 1);
    chk("rst_empty", free_list_empty, 0);
    chk("rst_valid", alloc_valid, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_preg", alloc_preg, 32);

    // Push while full is dropped and sets the sticky error
    free_valid = 1; free_preg = 7; tick(); idle(); #1;
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", free_count, 32);
    chk("ovf_full", free_list_full, 1);
    tick();
    chk("ovf_sticky", overflow_err, 1);
    do_reset();
    chk("ovf_clr", overflow_err, 0);

    // Drain all 32 tags in order
    pop_n(32, 32);
    chk("drain_empty", free_list_empty, 1);
    chk("drain_count", free_count, 0);
    chk("drain_full", free_list_full, 0);

    // Empty list: same-cycle push is not bypassed to the pop
    alloc_req = 1; free_valid = 1; free_preg = 5; #1;
    chk("nobyp_valid", alloc_valid, 0);
    tick();
    free_valid = 0; #1;
    chk("nobyp_count", free_count, 1);
    chk("nobyp_valid2", alloc_valid, 1);
    chk("nobyp_tag", alloc_preg, 5);
    tick(); idle(); #1;
    chk("nobyp_empty", free_list_empty, 1);

    // Pop 3, commit one, then flush
    do_reset();
    pop_n(3, 32);
    chk("p3_count", free_count, 29);
    commit_alloc = 1; tick(); idle();
    flush = 1; alloc_req = 1; #1;
    chk("flush_blocks", alloc_valid, 0);
    tick(); idle(); #1;
    chk("flush_count", free_count, 31);
    chk("flush_preg", alloc_preg, 33);

    // Flush with same-cycle commit folds the commit in
    do_reset();
    pop_n(3, 32);
    flush = 1; commit_alloc = 1; tick(); idle(); #1;
    chk("flcm_count", free_count, 31);
    chk("flcm_preg", alloc_preg, 33);

    // Wrap: steady pop/push of returned tags, tag order preserved across index wrap
    do_reset();
    for (int i = 32; i < 64; i++) q.push_back(i);
    alloc_req = 1; #1;
    chk("wrap_first", alloc_preg, 32);
    tick();
    held = q.pop_front();
    for (int c = 0; c < 40; c++) begin
      alloc_req = 1; commit_alloc = 1; free_valid = 1; free_preg = PREG_W'(held); #1;
      chk("wrap_valid", alloc_valid, 1);
      chk("wrap_tag", alloc_preg, q[0]);
      chk("wrap_count", free_count, 31);
      chk("wrap_flags", {free_list_empty, free_list_full}, 0);
      tick();
      q.push_back(held);
      held = q.pop_front();
    end
    // Drain: retire the last allocation and return its old mapping
    idle(); commit_alloc = 1; free_valid = 1; free_preg = PREG_W'(held); tick(); idle(); #1;
    chk("drain_full2", free_list_full, 1);
    chk("drain_count2", free_count, 32);
    chk("drain_ovf", overflow_err, 0);
    q.push_back(held);
    // Flush after drain must not disturb a fully committed list
    flush = 1; tick(); idle(); #1;
    chk("post_flush_count", free_count, 32);
    chk("post_flush_preg", alloc_preg, q[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
